div_sched: RTL and testbench
============================

# div_sched

Round-robin scheduler sharing one fixed-latency pipelined divider among `N_REQ` requesters, e.g. the per-cell gradient units that need gy/gx for orientation binning. It registers the granted operands into the divider, tracks requester IDs through a tag pipeline matched to the divider latency, and collects results in a response FIFO. Issue is credit-gated so that no result is ever lost when the consumer stalls.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters; range 2..16.
- `ID_W`, default 2: requester ID width; 2^ID_W ≥ N_REQ.
- `A_W`, default 8: dividend width.
- `B_W`, default 8: divisor width.
- `O_W`, default 20: quotient width, Q4.16.
- `DIV_LAT`, default 12: number of clk edges from the edge that samples `div_a`/`div_b` up to and including the edge after which `div_o` holds that result.
- `FIFO_D`, default 16: response FIFO depth and credit limit; must be ≥ DIV_LAT+1 for full throughput.

Ports (clock and reset listed first):
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, N_REQ: per-requester request.
- `req_ready`, out, N_REQ: one-hot grant. A handshake is `req_valid[i] & req_ready[i]`.
- `req_a`, in, N_REQ*A_W: dividend magnitudes; requester i occupies bits [i*A_W +: A_W].
- `req_b`, in, N_REQ*B_W: divisor magnitudes.
- `req_sign_diff`, in, N_REQ: 1 means the quotient is negative.
- `div_a`, out, A_W: registered dividend to the divider.
- `div_b`, out, B_W: registered divisor to the divider.
- `div_sign_diff`, out, 1: registered sign to the divider.
- `div_o`, in, O_W: divider result.
- `rsp_valid`, out, 1: FIFO not empty.
- `rsp_ready`, in, 1: consumer pops on `rsp_valid & rsp_ready`.
- `rsp_data`, out, O_W: head-of-FIFO quotient.
- `rsp_id`, out, ID_W: head-of-FIFO requester ID.
- `busy`, out, 1: credit count ≠ 0.

## Operation

- **Credit counter `cnt`** (0..FIFO_D): counts issued-but-not-popped operations.
  - +1 on a handshake.
  - −1 on a pop.
  - Unchanged when a handshake and a pop happen in the same cycle.
  - Grants are allowed only while `cnt < FIFO_D`.
- **Arbiter:**
  - Pointer `ptr` resets to 0.
  - The grant goes to the first `i` with `req_valid[i]` set, searching from `ptr` upward with wrap-around.
  - `req_ready` is combinational from `req_valid`, `ptr` and the credit check; at most one bit is set.
  - After a grant to `i`, `ptr` becomes (i+1) mod N_REQ. With no grant, `ptr` holds.
  - Requesters hold `req_valid` and operands stable until granted.
- **Issue register:**
  - On a handshake, latch `req_a[i]`, `req_b[i]`, `req_sign_diff[i]` into `div_a`, `div_b`, `div_sign_diff`, and latch {valid=1, id=i} into the issue tag.
  - With no handshake, issue tag valid goes to 0 and the operand registers hold.
- **Tag pipeline:**
  - DIV_LAT stages of {valid, id}, shifting every cycle. The issue tag enters stage 0.
  - When stage DIV_LAT−1 is valid, `div_o` belongs to that tag. {div_o, id} is written to the FIFO at the next edge.
  - FIFO overflow is impossible by construction of the credits; overflow is an assertion failure.
- **Response FIFO:** show-ahead, depth FIFO_D, `rsp_data`/`rsp_id` valid whenever `rsp_valid` is high. A write and a pop may occur in the same cycle, including when the FIFO is full.
- **Arithmetic:** the block has none. Divide-by-zero, saturation and clamping are the divider's job, and its output is passed through unmodified.
- **Reset (asynchronous, any time):**
  - `cnt`, `ptr`, all tag valids and the FIFO pointers clear.
  - `div_a`, `div_b`, `div_sign_diff` and the issue registers go to 0.
  - Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0.
  - In-flight operations are dropped. The divider has no reset, so stale `div_o` is ignored because every tag is invalid.

## Timing

- Handshake at edge H:
  - After edge H, operands are on the `div_*` outputs.
  - Edge H+1: the divider samples them and the tag enters stage 0.
  - After edge H+DIV_LAT, `div_o` is valid and the tag is at stage DIV_LAT−1.
  - Edge H+DIV_LAT+1: FIFO write.
  - Result: `rsp_valid` rises DIV_LAT+1 cycles after the handshake, 13 cycles at the defaults.
- Throughput is one issue per cycle while `cnt < FIFO_D`.
- Responses leave in issue order.
- After a pop at edge P with the FIFO full, a grant becomes possible in the cycle following P.

## Test plan

- **Single request:** requester 2 sends a=100, b=50, sign=0 → exactly one response, 13 cycles after the handshake, `rsp_data`=0x20000, `rsp_id`=2; `busy` returns to 0 after the pop.
- **Negative quotient:** requester 0 sends a=50, b=100, sign=1 → `rsp_data`=0xF8000 (−0.5), `rsp_id`=0.
- **Full contention:** all four `req_valid` held high, `rsp_ready`=1 → grants in order 0,1,2,3,0,…; after the fill latency, one response per cycle with IDs in that order; no cycle with two bits of `req_ready` set.
- **Backpressure:** `rsp_ready`=0 and all requesters active → exactly 16 handshakes, then `req_ready`=0 and `rsp_valid`=1 held. Raise `rsp_ready` → 16 responses in issue order, with granting resuming the cycle after the first pop.
- **Divide by zero:** a=7, b=0, sign=0 → `rsp_data`=0x5ABD9, the divider's clamp, passed through unmodified.
- **Reset mid-flight:** issue 5 requests, assert `rst` 4 cycles later for 2 cycles → immediately `rsp_valid`=0 and `busy`=0; no response ever appears for the dropped requests; a new request issued after reset returns the correct result with 13-cycle latency.

Source files
------------

// File: rtl/div_sched_if.sv
// div_sched_if: requester, divider and response signals of the shared-divider scheduler
interface div_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int O_W   = 20
);
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*A_W-1:0] req_a;
  logic [N_REQ*B_W-1:0] req_b;
  logic [N_REQ-1:0]     req_sign_diff;
  logic [A_W-1:0]       div_a;
  logic [B_W-1:0]       div_b;
  logic                 div_sign_diff;
  logic [O_W-1:0]       div_o;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [O_W-1:0]       rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 busy;
  modport slave (
    input  req_valid, req_a, req_b, req_sign_diff, div_o, rsp_ready,
    output req_ready, div_a, div_b, div_sign_diff, rsp_valid, rsp_data, rsp_id, busy
  );
  modport master (
    output req_valid, req_a, req_b, req_sign_diff, div_o, rsp_ready,
    input  req_ready, div_a, div_b, div_sign_diff, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/div_sched.sv
// div_sched: round-robin, credit-gated issue into a fixed-latency divider with an ID tag pipeline and response FIFO
module div_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 8,
  parameter int B_W     = 8,
  parameter int O_W     = 20,
  parameter int DIV_LAT = 12,
  parameter int FIFO_D  = 16
) (
  input logic clk,
  input logic rst,
  div_sched_if.slave bus
);
  localparam int CW = $clog2(FIFO_D + 1);
  localparam int AW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_D);
  localparam logic [AW-1:0] LAST = AW'(FIFO_D - 1);
  logic [ID_W-1:0] ptr, gid, iid;
  logic [CW-1:0]   cnt, fcnt;
  logic [AW-1:0]   wp, rp;
  logic [A_W-1:0]  sel_a;
  logic [B_W-1:0]  sel_b;
  logic            sel_s, found, hs, pop, wr, iv;
  int              d, best;
  logic [DIV_LAT-1:0] tv;
  logic [ID_W-1:0] tid [DIV_LAT];
  logic [O_W-1:0]  mem_d [FIFO_D];
  logic [ID_W-1:0] mem_i [FIFO_D];
  // the valid requester with the smallest wrap-around distance from ptr wins
  always_comb begin
    best = N_REQ;
    d = 0;
    gid = '0;
    sel_a = '0;
    sel_b = '0;
    sel_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      d = (i >= int'(ptr)) ? i - int'(ptr) : i + N_REQ - int'(ptr);
      if (bus.req_valid[i] && d < best) begin
        best = d;
        gid = ID_W'(i);
        sel_a = bus.req_a[i*A_W +: A_W];
        sel_b = bus.req_b[i*B_W +: B_W];
        sel_s = bus.req_sign_diff[i];
      end
    end
    found = best < N_REQ;
  end
  assign hs = found && cnt < FULL && !rst;
  assign bus.req_ready = hs ? N_REQ'(1) << gid : '0;
  assign pop = bus.rsp_valid & bus.rsp_ready;
  assign wr = tv[DIV_LAT-1];
  assign bus.rsp_valid = fcnt != '0;
  assign bus.busy = cnt != '0;
  assign bus.rsp_data = bus.rsp_valid ? mem_d[rp] : '0;
  assign bus.rsp_id = bus.rsp_valid ? mem_i[rp] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
      iv <= 1'b0;
      iid <= '0;
      tv <= '0;
      bus.div_a <= '0;
      bus.div_b <= '0;
      bus.div_sign_diff <= 1'b0;
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
    end else begin
      cnt <= cnt + CW'(hs) - CW'(pop);
      iv <= hs;
      if (hs) begin
        ptr <= (gid == ID_W'(N_REQ - 1)) ? '0 : gid + 1'b1;
        iid <= gid;
        bus.div_a <= sel_a;
        bus.div_b <= sel_b;
        bus.div_sign_diff <= sel_s;
      end
      tv <= {tv[DIV_LAT-2:0], iv};
      if (wr) wp <= (wp == LAST) ? '0 : wp + 1'b1;
      if (pop) rp <= (rp == LAST) ? '0 : rp + 1'b1;
      fcnt <= fcnt + CW'(wr) - CW'(pop);
    end
  end
  // tag IDs and FIFO storage need no reset: only valid tags and occupied slots are ever used
  always_ff @(posedge clk) begin
    tid[0] <= iid;
    for (int i = 1; i < DIV_LAT; i++) tid[i] <= tid[i-1];
    if (wr) begin
      mem_d[wp] <= bus.div_o;
      mem_i[wp] <= tid[DIV_LAT-1];
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr && fcnt == FULL && !pop));
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: table vectors, corner sequences and a randomized run against a transaction-level model
module tb_div_sched;
  localparam int N = 4, IW = 2, AW = 8, BW = 8, OW = 20, LAT = 12, FD = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  div_sched_if #(.N_REQ(N), .ID_W(IW), .A_W(AW), .B_W(BW), .O_W(OW)) bus();
  div_sched #(.N_REQ(N), .ID_W(IW), .A_W(AW), .B_W(BW), .O_W(OW), .DIV_LAT(LAT), .FIFO_D(FD))
    dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // stand-in divider: Q4.16 magnitude, saturating, fixed clamp value for b==0
  function automatic logic [OW-1:0] quot(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic s);
    logic [31:0] q;
    if (b == '0) return 20'h5ABD9;
    q = ({24'd0, a} << 16) / {24'd0, b};
    if (q > 32'h7FFFF) q = 32'h7FFFF;
    return s ? OW'(-q) : q[OW-1:0];
  endfunction
  logic [OW-1:0] dpipe [LAT];
  always @(posedge clk) begin
    dpipe[0] <= quot(bus.div_a, bus.div_b, bus.div_sign_diff);
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign bus.div_o = dpipe[LAT-1];
  typedef struct {logic [OW-1:0] d; int id; int rdy;} exp_t;
  exp_t q[$];
  int glog[$];
  int cnt_m = 0, ptr_m = 0, ncyc = 0, hs_cnt = 0, g_m;
  logic erv;
  logic [N-1:0] last_hs = '0;
  // transaction model: credits, round-robin pointer and an in-order queue of results with ready times
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      q.delete();
      cnt_m = 0;
      ptr_m = 0;
      last_hs = '0;
    end else begin
      g_m = -1;
      if (cnt_m < FD)
        for (int k = 0; k < N; k++)
          if (g_m < 0 && ((bus.req_valid >> ((ptr_m + k) % N)) & 1) != 0) g_m = (ptr_m + k) % N;
      chk("req_ready", 32'(bus.req_ready), g_m < 0 ? 0 : 32'(1) << g_m);
      erv = q.size() > 0 && q[0].rdy <= ncyc;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(erv));
      if (erv) begin
        chk("rsp_data", 32'(bus.rsp_data), 32'(q[0].d));
        chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
      end
      chk("busy", 32'(bus.busy), 32'(cnt_m != 0));
      last_hs = bus.req_valid & bus.req_ready;
      for (int i = 0; i < N; i++) if (last_hs[i[IW-1:0]]) begin
        glog.push_back(i);
        hs_cnt++;
      end
      if (erv && bus.rsp_ready) begin
        void'(q.pop_front());
        cnt_m--;
      end
      if (g_m >= 0) begin
        q.push_back('{quot(AW'(bus.req_a >> (g_m*AW)), BW'(bus.req_b >> (g_m*BW)),
                           bus.req_sign_diff[g_m[IW-1:0]]), g_m, ncyc + LAT + 2});
        cnt_m++;
        ptr_m = (g_m + 1) % N;
      end
    end
    ncyc++;
  end
  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b, input logic s);
    logic [N*AW-1:0] ma;
    logic [N*BW-1:0] mb;
    ma = {{(N*AW-AW){1'b0}}, {AW{1'b1}}} << (i*AW);
    mb = {{(N*BW-BW){1'b0}}, {BW{1'b1}}} << (i*BW);
    bus.req_a = (bus.req_a & ~ma) | ((N*AW)'(a) << (i*AW));
    bus.req_b = (bus.req_b & ~mb) | ((N*BW)'(b) << (i*BW));
    bus.req_sign_diff[i[IW-1:0]] = s;
  endtask
  task automatic drain();
    int n;
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", 32'(bus.busy), 0);
  endtask
  typedef struct {int id; logic [AW-1:0] a; logic [BW-1:0] b; logic s; logic [OW-1:0] exp;} vec_t;
  task automatic run_vec(input vec_t v);
    int n, lat;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    set_op(v.id, v.a, v.b, v.s);
    bus.req_valid = N'(1) << v.id;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[v.id[IW-1:0]] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("vec_grant", 32'(n < 50), 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    lat = 0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("vec_latency", 32'(lat), LAT + 1);
    chk("vec_data", 32'(bus.rsp_data), 32'(v.exp));
    chk("vec_id", 32'(bus.rsp_id), 32'(v.id));
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("vec_busy_after_pop", 32'(bus.busy), 0);
    chk("vec_empty_after_pop", 32'(bus.rsp_valid), 0);
  endtask
  vec_t vt[6];
  int n, seen;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    vt[0] = '{2, 8'd100, 8'd50,  1'b0, 20'h20000};
    vt[1] = '{0, 8'd50,  8'd100, 1'b1, 20'hF8000};
    vt[2] = '{1, 8'd7,   8'd0,   1'b0, 20'h5ABD9};
    vt[3] = '{1, 8'd3,   8'd4,   1'b0, 20'h0C000};
    vt[4] = '{3, 8'd1,   8'd3,   1'b1, 20'hFAAAB};
    vt[5] = '{3, 8'd255, 8'd1,   1'b0, 20'h7FFFF};
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_sign_diff = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // full contention straight out of reset: grants rotate 0,1,2,3,...
    for (int i = 0; i < N; i++) set_op(i, AW'(10 + i), BW'(3 + i), i[0]);
    glog.delete();
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    repeat (40) @(posedge clk);
    #1 bus.req_valid = '0;
    chk("contention_count", 32'(glog.size() >= 12), 1);
    for (int i = 0; i < 12; i++) chk("grant_order", 32'(glog[i]), 32'(i % N));
    drain();
    for (int i = 0; i < 6; i++) run_vec(vt[i]);
    // backpressure: credits stop issue at FIFO_D, first pop reopens granting
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    hs_cnt = 0;
    bus.req_valid = '1;
    repeat (40) @(posedge clk);
    #1 chk("bp_handshakes", 32'(hs_cnt), FD);
    @(negedge clk);
    chk("bp_ready_low", 32'(bus.req_ready), 0);
    chk("bp_rsp_held", 32'(bus.rsp_valid), 1);
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_regrant", 32'(bus.req_ready != '0), 1);
    drain();
    // reset with operations in flight
    @(posedge clk); #1;
    hs_cnt = 0;
    bus.req_valid = '1;
    n = 0;
    while (hs_cnt < 5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = '0;
    chk("rst_issued", 32'(hs_cnt), 5);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_async_busy", 32'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("rst_dropped", 32'(seen), 0);
    run_vec(vt[0]);
    // randomized traffic with random and sustained backpressure
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (!bus.req_valid[i[IW-1:0]] || last_hs[i[IW-1:0]]) begin
          bus.req_valid[i[IW-1:0]] = ($urandom % 3) != 0;
          set_op(i, AW'($urandom), ($urandom % 8 == 0) ? '0 : BW'($urandom), 1'($urandom));
        end
      bus.rsp_ready = (c >= 300 && c < 360) ? 1'b0 : (($urandom % 4) != 0);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
